lfsr_bist_engine: RTL and testbench

Parametrised successor to the fixed 7-bit pattern generator in the BISTed-circuit flow. The block has one LFSR core with a programmable polynomial and two modes: test-pattern generation (TPG) and multiple-input signature register (MISR) compaction. It adds a run-time seed load, a pattern budget with a done pulse, and a period-wrap flag. It drives the CUT inputs in TPG mode and compacts CUT responses in MISR mode.

---
 rtl/lfsr_bist_pkg.sv | 9 +
 rtl/lfsr_step.sv | 18 +
 rtl/lfsr_bist_engine.sv | 76 +++++++
 tb/tb_lfsr_bist_engine.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/lfsr_bist_pkg.sv
// lfsr_bist_pkg: shared mode encodings, FSM states and feedback parity helper
package lfsr_bist_pkg;
  localparam logic MODE_TPG = 1'b0;
  localparam logic MODE_MISR = 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic fb_parity(input logic [31:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: combinational LFSR/MISR next-state function
module lfsr_step
  import lfsr_bist_pkg::*;
#(
  parameter int W = 7,
  parameter logic [W-1:0] TAPS = 7'h41
) (
  input  logic [W-1:0] state,
  input  logic [W-1:0] misr_in,
  input  logic         mode,
  output logic [W-1:0] next
);
  logic [W-1:0] shifted;
  always_comb begin
    shifted = {state[W-2:0], fb_parity(32'(state & TAPS))};
    next = (mode == MODE_MISR) ? shifted ^ misr_in : shifted;
  end
endmodule

// File: rtl/lfsr_bist_engine.sv
// lfsr_bist_engine: programmable LFSR pattern generator / MISR with budget and wrap flags
module lfsr_bist_engine
  import lfsr_bist_pkg::*;
#(
  parameter int W = 7,
  parameter logic [W-1:0] TAPS = 7'h41,
  parameter logic [W-1:0] SEED_DEF = 7'h40,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             seed_load,
  input  logic [W-1:0]     seed,
  input  logic [W-1:0]     misr_in,
  input  logic             misr_valid,
  input  logic [CNT_W-1:0] num_pat,
  output logic             out_valid,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] pat_cnt,
  output logic             done,
  output logic             period_wrap
);
  state_t state, state_nxt;
  logic enable_ff, adv, hit;
  logic [W-1:0] seed_reg, seed_eff, step_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  lfsr_step #(.W(W), .TAPS(TAPS)) u_step (
    .state(dout),
    .misr_in(misr_in),
    .mode(mode),
    .next(step_nxt)
  );
  always_comb begin
    adv = (state == RUN) && enable_ff && (mode == MODE_TPG || misr_valid);
    cnt_nxt = &pat_cnt ? pat_cnt : pat_cnt + 1'b1;
    hit = (num_pat != '0) && (cnt_nxt == num_pat);
    seed_eff = (seed == '0) ? SEED_DEF : seed;
    state_nxt = (state == IDLE && enable_ff) ? RUN :
                (state == RUN && !enable_ff) ? IDLE :
                (adv && hit) ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      enable_ff <= 1'b0;
      state <= IDLE;
      dout <= SEED_DEF;
      seed_reg <= SEED_DEF;
      pat_cnt <= '0;
      out_valid <= 1'b0;
      done <= 1'b0;
      period_wrap <= 1'b0;
    end else begin
      enable_ff <= enable;
      done <= 1'b0;
      period_wrap <= 1'b0;
      if (seed_load) begin
        seed_reg <= seed_eff;
        dout <= seed_eff;
        pat_cnt <= '0;
        out_valid <= 1'b0;
        state <= IDLE;
      end else begin
        state <= state_nxt;
        if (adv) begin
          dout <= step_nxt;
          pat_cnt <= cnt_nxt;
          out_valid <= 1'b1;
          done <= hit;
          period_wrap <= (step_nxt == seed_reg);
        end
      end
    end
  end
endmodule

// File: tb/tb_lfsr_bist_engine.sv
// tb_lfsr_bist_engine: directed self-checking bench for lfsr_bist_engine
module tb_lfsr_bist_engine;
  logic clk = 1'b0;
  logic reset, enable, mode, seed_load, misr_valid;
  logic [6:0] seed, misr_in, dout, m;
  logic [15:0] num_pat, pat_cnt;
  logic out_valid, done, period_wrap;
  int checks = 0;
  int errors = 0;
  logic [6:0] seq [8] = '{7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h7F, 7'h7E};
  lfsr_bist_engine dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .seed_load(seed_load), .seed(seed), .misr_in(misr_in),
    .misr_valid(misr_valid), .num_pat(num_pat), .out_valid(out_valid),
    .dout(dout), .pat_cnt(pat_cnt), .done(done), .period_wrap(period_wrap)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [6:0] model_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[0]};
  endfunction
  initial begin
    reset = 0; enable = 0; mode = 0; seed_load = 1; seed = 7'h55;
    misr_in = 0; misr_valid = 0; num_pat = 0;
    tick(); tick();
    chk("rst_dout", 32'(dout), 32'h40);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_cnt", 32'(pat_cnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wrap", 32'(period_wrap), 0);
    reset = 1; seed_load = 0; enable = 1;
    tick();
    chk("lat_k_dout", 32'(dout), 32'h40);
    chk("lat_k_valid", 32'(out_valid), 0);
    tick();
    chk("lat_k1_dout", 32'(dout), 32'h40);
    chk("lat_k1_valid", 32'(out_valid), 0);
    chk("lat_k1_cnt", 32'(pat_cnt), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("seq_dout", 32'(dout), 32'(seq[i]));
      chk("seq_valid", 32'(out_valid), 1);
      chk("seq_cnt", 32'(pat_cnt), 32'(i + 1));
    end
    m = 7'h7E;
    for (int n = 9; n <= 254; n++) begin
      tick();
      m = model_step(m);
      chk("free_dout", 32'(dout), 32'(m));
      chk("free_wrap", 32'(period_wrap), 32'(n == 127 || n == 254));
      if (n == 127) begin
        chk("wrap_cnt", 32'(pat_cnt), 127);
        chk("wrap_dout", 32'(dout), 32'h40);
      end
    end
    tick();
    chk("post_wrap_dout", 32'(dout), 32'h01);
    chk("post_wrap_flag", 32'(period_wrap), 0);
    enable = 0;
    tick();
    chk("pause_a_dout", 32'(dout), 32'h03);
    chk("pause_a_cnt", 32'(pat_cnt), 256);
    tick(); tick();
    chk("pause_dout", 32'(dout), 32'h03);
    chk("pause_cnt", 32'(pat_cnt), 256);
    chk("pause_done", 32'(done), 0);
    enable = 1;
    tick(); tick(); tick();
    chk("resume_dout", 32'(dout), 32'h07);
    chk("resume_cnt", 32'(pat_cnt), 257);
    num_pat = 16'd300;
    reset = 0;
    tick();
    chk("midrst_dout", 32'(dout), 32'h40);
    chk("midrst_cnt", 32'(pat_cnt), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_wrap", 32'(period_wrap), 0);
    reset = 1; num_pat = 16'd5; seed_load = 1; seed = 7'h40;
    tick();
    chk("ld_dout", 32'(dout), 32'h40);
    chk("ld_cnt", 32'(pat_cnt), 0);
    seed_load = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bud_dout", 32'(dout), 32'(seq[i]));
      chk("bud_done", 32'(done), 32'(i == 4));
    end
    chk("bud_cnt", 32'(pat_cnt), 5);
    tick();
    chk("done_pulse_end", 32'(done), 0);
    chk("done_hold_dout", 32'(dout), 32'h1F);
    enable = 0;
    tick(); tick();
    enable = 1;
    tick(); tick(); tick();
    chk("done_ign_dout", 32'(dout), 32'h1F);
    chk("done_ign_cnt", 32'(pat_cnt), 5);
    chk("done_ign_done", 32'(done), 0);
    chk("done_ign_valid", 32'(out_valid), 1);
    seed_load = 1; seed = 7'h00; num_pat = 0;
    tick();
    chk("zseed_dout", 32'(dout), 32'h40);
    chk("zseed_cnt", 32'(pat_cnt), 0);
    chk("zseed_valid", 32'(out_valid), 0);
    seed_load = 0;
    tick(); tick();
    chk("rerun_dout", 32'(dout), 32'h01);
    chk("rerun_cnt", 32'(pat_cnt), 1);
    seed_load = 1; seed = 7'h55;
    tick();
    chk("ldadv_dout", 32'(dout), 32'h55);
    chk("ldadv_cnt", 32'(pat_cnt), 0);
    chk("ldadv_valid", 32'(out_valid), 0);
    mode = 1; misr_in = 7'h01; misr_valid = 0; seed = 7'h00;
    tick();
    chk("misr_ld_dout", 32'(dout), 32'h40);
    seed_load = 0;
    tick();
    misr_valid = 1;
    tick();
    chk("misr1_dout", 32'(dout), 32'h00);
    chk("misr1_cnt", 32'(pat_cnt), 1);
    chk("misr1_valid", 32'(out_valid), 1);
    tick();
    chk("misr2_dout", 32'(dout), 32'h01);
    misr_valid = 0;
    tick(); tick();
    chk("misr_hold_dout", 32'(dout), 32'h01);
    chk("misr_hold_cnt", 32'(pat_cnt), 2);
    mode = 0;
    tick();
    chk("mode_sw_dout", 32'(dout), 32'h03);
    chk("mode_sw_cnt", 32'(pat_cnt), 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
